mul_seq: RTL and testbench

Request sequencer sitting directly upstream of `booth_multiplier`, turning a valid/ready operand stream into the multiplier's start/done protocol. It latches a signed 32×32 request and pulses `mul_start`. It waits for `mul_done` under a timeout, then returns the selected product slice on a valid/ready response channel. It is the ALU's only path into the multiplier.

---
 rtl/mul_seq.sv | 140 ++++++++++++++
 tb/tb_mul_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequencer in front of booth_multiplier: accepts one signed 32x32 request, pulses mul_start,
// waits on armed mul_done under a TIMEOUT, then returns a formatted product; MUL_SEQ_BYPASS_EN adds the 0/1 operand shortcut.
module mul_seq #(
   parameter int unsigned TIMEOUT = 127
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [1:0]  req_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] mul_m,
   output logic [31:0] mul_q,
   output logic        mul_start,
   input  logic [63:0] mul_result,
   input  logic        mul_done,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [31:0] m_q, m_d, q_q, q_d;
   logic [1:0]  op_q, op_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        armed_q, armed_d;
   logic [63:0] data_q, data_d;
   logic        err_q, err_d;

   function automatic logic [63:0] fmt(input logic [1:0] op, input logic [63:0] p);
      case (op)
         2'b01:   fmt = {32'b0, p[31:0]};
         2'b10:   fmt = {32'b0, p[63:32]};
         default: fmt = p;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         q_q     <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         armed_q <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         q_q     <= q_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      q_d     = q_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               m_d  = req_a;
               q_d  = req_b;
               op_d = req_op;
               if (req_op == 2'b11) begin
                  data_d  = '0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
`ifdef MUL_SEQ_BYPASS_EN
               else if (req_a == 32'd0 || req_b == 32'd0) begin
                  data_d  = '0;
                  err_d   = 1'b0;
                  state_d = S_RESP;
               end else if (req_a == 32'd1) begin
                  data_d  = fmt(req_op, {{32{req_b[31]}}, req_b});
                  err_d   = 1'b0;
                  state_d = S_RESP;
               end else if (req_b == 32'd1) begin
                  data_d  = fmt(req_op, {{32{req_a[31]}}, req_a});
                  err_d   = 1'b0;
                  state_d = S_RESP;
               end
`endif
               else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            armed_d = 1'b0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            // A done seen before any low sample belongs to the previous operation.
            if (!mul_done) armed_d = 1'b1;
            if (armed_q && mul_done) begin
               data_d  = fmt(op_q, mul_result);
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_d == 8'(TIMEOUT)) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign mul_start = (state_q == S_ISSUE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_data  = data_q;
   assign rsp_err   = err_q;
   assign mul_m     = m_q;
   assign mul_q     = q_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq with a behavioural multiplier stand-in driven on the falling edge.
module tb_mul_seq;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  req_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_err;
   logic [31:0] mul_m;
   logic [31:0] mul_q;
   logic        mul_start;
   logic [63:0] mul_result;
   logic        mul_done;
   logic        busy;

   int n_chk;
   int n_pass;
   int start_cnt;

   // multiplier stand-in controls
   bit model_en;
   int done_lat;
   int stale_n;

   mul_seq #(.TIMEOUT(127)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .mul_m      (mul_m),
      .mul_q      (mul_q),
      .mul_start  (mul_start),
      .mul_result (mul_result),
      .mul_done   (mul_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   initial begin
      start_cnt = 0;
      forever begin
         @(negedge clk);
         if (mul_start === 1'b1) start_cnt++;
      end
   end

   // Done drops after stale_n cycles past start, rises done_lat cycles after start.
   initial begin
      int     left;
      int     st;
      bit     pend;
      longint prod;
      pend = 0; left = 0; st = 0; prod = 0;
      forever begin
         @(negedge clk);
         if (model_en) begin
            if (mul_start === 1'b1) begin
               pend = 1;
               left = done_lat;
               st   = stale_n;
               prod = longint'($signed(mul_m)) * longint'($signed(mul_q));
               if (st == 0) mul_done = 1'b0;
            end else if (pend) begin
               if (st > 0) begin
                  st--;
                  if (st == 0) mul_done = 1'b0;
               end
               if (left > 0) left--;
               if (left == 0 && st == 0) begin
                  mul_result = prod;
                  mul_done   = 1'b1;
                  pend       = 0;
               end
            end
         end
      end
   end

   task automatic req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      @(negedge clk);
      chk("req_ready_before", req_ready, 1);
      req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int maxc, output int cyc);
      cyc = 1;
      while (rsp_valid !== 1'b1 && cyc < maxc) begin
         @(negedge clk);
         cyc++;
      end
      chk("rsp_seen", rsp_valid, 1);
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_req_ready"}, req_ready, 1);
      chk({pfx, "_rsp_valid"}, rsp_valid, 0);
      chk({pfx, "_rsp_data"},  rsp_data,  0);
      chk({pfx, "_rsp_err"},   rsp_err,   0);
      chk({pfx, "_mul_m"},     mul_m,     0);
      chk({pfx, "_mul_q"},     mul_q,     0);
      chk({pfx, "_mul_start"}, mul_start, 0);
      chk({pfx, "_busy"},      busy,      0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int cyc;
      int s0;
      int bad;
      logic [63:0] held;
      n_chk = 0; n_pass = 0;
      rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
      rsp_ready = 1'b1; mul_result = '0; mul_done = 1'b0;
      model_en = 1'b1; done_lat = 34; stale_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;

      // full product, 34-cycle multiplier
      s0 = start_cnt;
      req(32'd12345, 32'd6789, 2'b00);
      chk("full_start_n1", mul_start, 1);
      chk("full_busy", busy, 1);
      chk("full_req_ready_low", req_ready, 0);
      chk("full_mul_m", mul_m, 64'd12345);
      chk("full_mul_q", mul_q, 64'd6789);
      wait_rsp(200, cyc);
      chk("full_latency", cyc, 36);
      chk("full_data", rsp_data, 64'd83810205);
      chk("full_err", rsp_err, 0);
      chk("full_one_start", start_cnt - s0, 1);
      @(negedge clk);
      chk("full_rsp_one_cycle", rsp_valid, 0);

      // signed slices
      done_lat = 8;
      req(32'hFFFF_CFC7, 32'd6789, 2'b10);
      wait_rsp(200, cyc);
      chk("hi_neg_data", rsp_data, 64'h0000_0000_FFFF_FFFF);
      @(negedge clk);
      req(32'hFFFF_CFC7, 32'd6789, 2'b01);
      wait_rsp(200, cyc);
      chk("lo_neg_data", rsp_data, 64'h0000_0000_FB01_2863);
      @(negedge clk);
      req(32'h8000_0000, 32'h8000_0000, 2'b10);
      wait_rsp(200, cyc);
      chk("hi_minmin_data", rsp_data, 64'h0000_0000_4000_0000);
      chk("hi_minmin_err", rsp_err, 0);
      @(negedge clk);

      // illegal op
      s0 = start_cnt;
      req(32'd5, 32'd7, 2'b11);
      chk("ill_valid_n1", rsp_valid, 1);
      chk("ill_err", rsp_err, 1);
      chk("ill_data", rsp_data, 0);
      chk("ill_start", mul_start, 0);
      repeat (3) @(negedge clk);
      chk("ill_no_start", start_cnt - s0, 0);

      // stale done plus response backpressure
      chk("stale_done_high", mul_done, 1);
      done_lat = 10; stale_n = 4; rsp_ready = 1'b0;
      req(32'd100, 32'hFFFF_FFFD, 2'b00);
      wait_rsp(200, cyc);
      chk("stale_latency", cyc, 12);
      chk("stale_data", rsp_data, 64'hFFFF_FFFF_FFFF_FED4);
      held = rsp_data;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== held || rsp_err !== 1'b0 || req_ready !== 1'b0) bad++;
      end
      chk("bp_stable", bad, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_after_hs_valid", rsp_valid, 0);
      chk("bp_after_hs_ready", req_ready, 1);
      stale_n = 0;

      // timeout with done stuck low
      model_en = 1'b0; mul_done = 1'b0;
      req(32'd3, 32'd4, 2'b00);
      wait_rsp(300, cyc);
      chk("tmo_latency", cyc, 129);
      chk("tmo_err", rsp_err, 1);
      chk("tmo_data", rsp_data, 0);
      @(negedge clk);

      // reset in the middle of WAIT
      req(32'd7, 32'd9, 2'b01);
      repeat (50) @(negedge clk);
      chk("midwait_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 140; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || mul_start !== 1'b0) bad++;
      end
      chk("midrst_no_rsp", bad, 0);

      // recovers after reset
      model_en = 1'b1; done_lat = 5;
      req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01);
      chk("post_mul_q", mul_q, 64'hFFFF_FFFF);
      wait_rsp(200, cyc);
      chk("post_data", rsp_data, 64'd1);
      chk("post_err", rsp_err, 0);
      @(negedge clk);

`ifdef MUL_SEQ_BYPASS_EN
      s0 = start_cnt;
      req(32'd0, 32'd123456789, 2'b00);
      chk("byp_zero_valid_n1", rsp_valid, 1);
      chk("byp_zero_data", rsp_data, 0);
      chk("byp_zero_err", rsp_err, 0);
      @(negedge clk);
      req(32'd1, 32'hFFFF_FFFB, 2'b00);
      chk("byp_one_valid_n1", rsp_valid, 1);
      chk("byp_one_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFB);
      @(negedge clk);
      req(32'hFFFF_FFFB, 32'd1, 2'b10);
      chk("byp_hi_data", rsp_data, 64'h0000_0000_FFFF_FFFF);
      repeat (2) @(negedge clk);
      chk("byp_no_start", start_cnt - s0, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
